// File: rtl/div8_seq.sv
// -----------------------------------------------------------------------------
// div8_seq
//
// Sequential 8-bit unsigned restoring divider. It produces one quotient bit
// per clock by shift-and-subtract and uses a start/busy/done handshake.
//
// An operation accepted on edge E0 iterates on E1..E8. The result is presented
// with a one-cycle done pulse after E8. The block returns to IDLE on E9 and can
// accept the next start on the following edge. A zero divisor skips the
// iterations entirely: done follows E0 directly with quotient = 8'hFF,
// remainder = dividend and div_by_zero = 1.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset; clears state and all outputs
//   start        operation request, sampled only in IDLE
//   dividend     unsigned dividend, latched with start
//   divisor      unsigned divisor, latched with start
//   quotient     registered quotient of the last completed operation
//   remainder    registered remainder of the last completed operation
//   busy         high while the iterations are running
//   done         one-cycle completion pulse
//   div_by_zero  registered flag: last completed operation had divisor == 0
// -----------------------------------------------------------------------------
module div8_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] dividend,
    input  logic [7:0] divisor,
    output logic [7:0] quotient,
    output logic [7:0] remainder,
    output logic       busy,
    output logic       done,
    output logic       div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_reg;
    logic [7:0]  q_reg;       // dividend shifting out, quotient shifting in
    logic [7:0]  d_reg;       // latched divisor
    logic [8:0]  r_reg;       // partial remainder
    logic [3:0]  count_reg;   // completed iterations

    // -------------------------------------------------------------------------
    // One restoring iteration, computed combinationally from the current state.
    // The pair {r,q} shifts left by one, so the MSB of q enters r. r_reg always
    // holds a value below the divisor after a step, so r_reg[8] is zero on
    // entry to every iteration and the shifted remainder fits in 9 bits.
    // -------------------------------------------------------------------------
    logic [8:0]  r_shift;
    logic [7:0]  q_shift;
    logic [8:0]  d_inv;
    logic [8:0]  trial;
    logic [9:0]  carry;
    logic        borrow;
    logic [8:0]  r_next;
    logic [7:0]  q_next;
    logic        unused_r_msb;

    assign r_shift      = {r_reg[7:0], q_reg[7]};
    assign q_shift      = {q_reg[6:0], 1'b0};
    assign unused_r_msb = r_reg[8];

    // Trial subtraction r_shift - {0,d} as r_shift + ~{0,d} + 1. It uses the
    // same full-adder ripple structure as the companion adder datapath.
    assign d_inv    = ~{1'b0, d_reg};
    assign carry[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < 9; gi++) begin : g_sub
            assign trial[gi]   = r_shift[gi] ^ d_inv[gi] ^ carry[gi];
            assign carry[gi+1] = (r_shift[gi] & d_inv[gi])
                               | (r_shift[gi] & carry[gi])
                               | (d_inv[gi]   & carry[gi]);
        end
    endgenerate

    // No carry out of the 9-bit two's complement add means the trial went
    // negative: keep (restore) the shifted remainder and emit a 0 quotient bit.
    assign borrow = ~carry[9];
    assign r_next = borrow ? r_shift : trial;
    assign q_next = {q_shift[7:1], ~borrow};

    // -------------------------------------------------------------------------
    // Control FSM and datapath registers. All outputs are registered.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            q_reg       <= 8'd0;
            d_reg       <= 8'd0;
            r_reg       <= 9'd0;
            count_reg   <= 4'd0;
            quotient    <= 8'd0;
            remainder   <= 8'd0;
            div_by_zero <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        q_reg     <= dividend;
                        d_reg     <= divisor;
                        r_reg     <= 9'd0;
                        count_reg <= 4'd0;
                        if (divisor != 8'd0) begin
                            state_reg <= RUN;
                            busy      <= 1'b1;
                        end else begin
                            // Divide by zero: present the result right away.
                            state_reg   <= DONE;
                            done        <= 1'b1;
                            quotient    <= 8'hFF;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end
                    end
                end

                RUN: begin
                    q_reg     <= q_next;
                    r_reg     <= r_next;
                    count_reg <= count_reg + 4'd1;
                    if (count_reg == 4'd7) begin
                        // Eighth iteration: load the outputs from this step.
                        state_reg   <= DONE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        quotient    <= q_next;
                        remainder   <= r_next[7:0];
                        div_by_zero <= 1'b0;
                    end
                end

                DONE: begin
                    // start is ignored here; the request must come in IDLE.
                    done      <= 1'b0;
                    state_reg <= IDLE;
                end

                default: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule
